// File: rtl/limber_gnrl_piso.sv
// limber_gnrl_piso: parallel-in serial-out shifter; define LIMBER_GNRL_PISO_MSB_FIRST_EN for MSB-first beat order
module limber_gnrl_piso #(
   parameter int DW = 1,
   parameter int DP = 4
) (
   input  logic             clk,
   input  logic             rst_asyn_n,
   input  logic             pi_vld,
   output logic             pi_rdy,
   input  logic [DW*DP-1:0] pi,
   output logic             so_vld,
   input  logic             so_rdy,
   output logic [DW-1:0]    so,
   output logic             so_last,
   output logic             busy
);
   localparam int CW = (DP > 1) ? $clog2(DP) : 1;
   localparam logic [0:0] IDLE = 1'b0, SHIFT = 1'b1;
   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DW*DP-1:0] sr_q, sr_d;
   logic [DW-1:0]    so_q, so_d;
   logic             so_last_q, so_last_d;
   logic             acc, xfer;
   int               nxt;
   function automatic logic [DW-1:0] beat(input logic [DW*DP-1:0] w, input int k);
`ifdef LIMBER_GNRL_PISO_MSB_FIRST_EN
      return w[(DP-1-k)*DW +: DW];
`else
      return w[k*DW +: DW];
`endif
   endfunction
   assign so_vld  = state_q == SHIFT;
   assign busy    = so_vld;
   assign so      = so_q;
   assign so_last = so_last_q;
   assign pi_rdy  = (state_q == IDLE) | (so_rdy & so_last_q);
   assign acc     = pi_vld & pi_rdy;
   assign xfer    = so_vld & so_rdy;
   // saturate so the lookahead index never leaves the word
   assign nxt     = (int'(cnt_q) == DP-1) ? int'(cnt_q) : int'(cnt_q) + 1;
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sr_d      = sr_q;
      so_d      = so_q;
      so_last_d = so_last_q;
      if (acc) begin
         state_d   = SHIFT;
         cnt_d     = '0;
         sr_d      = pi;
         so_d      = beat(pi, 0);
         so_last_d = DP == 1;
      end else if (xfer && so_last_q) begin
         state_d   = IDLE;
         so_last_d = 1'b0;
      end else if (xfer) begin
         cnt_d     = CW'(nxt);
         so_d      = beat(sr_q, nxt);
         so_last_d = nxt == DP-1;
      end
   end
   always_ff @(posedge clk or negedge rst_asyn_n) begin
      if (!rst_asyn_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sr_q      <= '0;
         so_q      <= '0;
         so_last_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sr_q      <= sr_d;
         so_q      <= so_d;
         so_last_q <= so_last_d;
      end
   end
endmodule

// File: tb/tb_limber_gnrl_piso.sv
// tb_limber_gnrl_piso: scoreboard bench for limber_gnrl_piso (DW=4/DP=4 and DW=8/DP=1 instances)
module tb_limber_gnrl_piso;
   logic        clk = 1'b0;
   logic        rst_asyn_n = 1'b0;
   logic        pi_vld = 1'b0, pi_rdy, so_vld, so_rdy = 1'b0, so_last, busy;
   logic [15:0] pi = '0;
   logic [3:0]  so;
   logic        a_vld = 1'b0, a_rdy, a_so_vld, a_so_rdy = 1'b0, a_last, a_busy;
   logic [7:0]  a_pi = '0, a_so;
   logic [4:0]  q[$];
   int          n_cmp = 0, n_err = 0;
   logic        rdy_seen;
   always #5 clk = ~clk;
   limber_gnrl_piso #(.DW(4), .DP(4)) u0 (
      .clk(clk), .rst_asyn_n(rst_asyn_n), .pi_vld(pi_vld), .pi_rdy(pi_rdy), .pi(pi),
      .so_vld(so_vld), .so_rdy(so_rdy), .so(so), .so_last(so_last), .busy(busy)
   );
   limber_gnrl_piso #(.DW(8), .DP(1)) u1 (
      .clk(clk), .rst_asyn_n(rst_asyn_n), .pi_vld(a_vld), .pi_rdy(a_rdy), .pi(a_pi),
      .so_vld(a_so_vld), .so_rdy(a_so_rdy), .so(a_so), .so_last(a_last), .busy(a_busy)
   );
   function automatic logic [3:0] mbeat(input logic [15:0] w, input int k);
`ifdef LIMBER_GNRL_PISO_MSB_FIRST_EN
      return w[(3-k)*4 +: 4];
`else
      return w[k*4 +: 4];
`endif
   endfunction
   task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s got %h want %h", tag, o, e);
      end
   endtask
   // drive one cycle's inputs, then score whatever the DUT shows before the edge
   task automatic step(input logic v, input logic [15:0] w, input logic r);
      @(negedge clk);
      pi_vld = v;
      pi = w;
      so_rdy = r;
      #1;
      rdy_seen = pi_rdy;
      if (pi_vld && pi_rdy)
         for (int k = 0; k < 4; k++) q.push_back({mbeat(w, k), 1'(k == 3)});
      if (so_vld) begin
         if (q.size() == 0) chk("orphan_beat", 16'(so_vld), 16'd0);
         else begin
            chk("beat", 16'({so, so_last}), 16'(q[0]));
            if (so_rdy) void'(q.pop_front());
         end
      end
   endtask
   task automatic drain();
      int g = 0;
      while (q.size() > 0 && g < 20) begin
         step(1'b0, 16'h0, 1'b1);
         g++;
      end
      chk("drain_left", 16'(q.size()), 16'd0);
      step(1'b0, 16'h0, 1'b1);
      chk("idle_vld", 16'(so_vld), 16'd0);
      chk("idle_rdy", 16'(pi_rdy), 16'd1);
   endtask
   initial begin
      #3;
      chk("rst_vld", 16'(so_vld), 16'd0);
      chk("rst_so", 16'(so), 16'd0);
      chk("rst_last", 16'(so_last), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      @(negedge clk);
      rst_asyn_n = 1'b1;
      #1;
      chk("rst_rdy", 16'(pi_rdy), 16'd1);
      step(1'b1, 16'hA5C3, 1'b1);
      drain();
      step(1'b1, 16'hA5C3, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      drain();
      step(1'b1, 16'h1234, 1'b1);
      chk("b2b_rdy0", 16'(rdy_seen), 16'd1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 16'hBEEF, 1'b1);
         chk("b2b_rdy", 16'(rdy_seen), 16'(i == 3));
         chk("b2b_vld", 16'(so_vld), 16'd1);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 16'h0, 1'b1);
         chk("b2b_vld2", 16'(so_vld), 16'd1);
      end
      drain();
      step(1'b1, 16'hA5C3, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      @(posedge clk);
      #2;
      rst_asyn_n = 1'b0;
      #1;
      chk("mid_rst_vld", 16'(so_vld), 16'd0);
      chk("mid_rst_so", 16'(so), 16'd0);
      chk("mid_rst_last", 16'(so_last), 16'd0);
      q.delete();
      @(negedge clk);
      rst_asyn_n = 1'b1;
      step(1'b1, 16'h00F1, 1'b1);
      drain();
      @(negedge clk);
      a_vld = 1'b1;
      a_pi = 8'h5A;
      a_so_rdy = 1'b1;
      @(negedge clk);
      chk("dp1_so0", 16'(a_so), 16'h5A);
      chk("dp1_last0", 16'(a_last), 16'd1);
      chk("dp1_rdy", 16'(a_rdy), 16'd1);
      a_pi = 8'h3C;
      @(negedge clk);
      chk("dp1_so1", 16'(a_so), 16'h3C);
      chk("dp1_last1", 16'(a_last), 16'd1);
      chk("dp1_vld1", 16'(a_so_vld), 16'd1);
      a_vld = 1'b0;
      @(negedge clk);
      chk("dp1_idle", 16'(a_so_vld), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/limber_gnrl_piso.md
Name: limber_gnrl_piso

Overview:
- Parallel-in serial-out shifter. It accepts one DW*DP-bit word over a valid/ready handshake and emits it as DP beats of DW bits on a valid/ready stream.
- Transmit-side counterpart of the generic DFF shift chain. It packs words for serial links and narrow buses inside Limber XPLOR.
- All outputs except pi_rdy are registered. It supports full throughput: one beat per cycle with no bubble between words.

Parameters:
- DW, 1, width of one serial beat in bits (>=1)
- DP, 4, beats per parallel word (>=1); parallel word width is DW*DP

Ports:
- clk  input  1  clock; all state changes on posedge
- rst_asyn_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- pi_vld  input  1  parallel word valid
- pi_rdy  output  1  block can accept a word this cycle (combinational)
- pi  input  DW*DP  parallel word; beat k = pi[k*DW +: DW]
- so_vld  output  1  serial beat valid
- so_rdy  input  1  downstream accepts beat
- so  output  DW  current serial beat
- so_last  output  1  current beat is the final beat of its word
- busy  output  1  a word is held (equals so_vld)

Behaviour:
- Reset values (asserted while rst_asyn_n=0, asynchronous):
  - so_vld=0, so=0, so_last=0, busy=0
  - beat counter cnt=0, shift register sr=0, state IDLE
  - pi_rdy=1 immediately after reset release.
- States:
  - IDLE: no word held.
  - SHIFT: word held, so_vld=1.
- Handshakes:
  - Word accept: pi_vld & pi_rdy at a clock edge.
  - Beat transfer: so_vld & so_rdy at a clock edge.
- pi_rdy = (state==IDLE) | (so_vld & so_rdy & so_last). Back-to-back acceptance is allowed on the last-beat handshake.
- Word accept:
  - sr <= pi, cnt <= 0, state <= SHIFT.
  - so <= beat 0 and so_vld <= 1 on the same edge.
  - so_last <= (DP==1).
  - Latency: first beat visible the cycle after acceptance.
- Beat transfer, not last:
  - cnt <= cnt+1.
  - so <= next beat.
  - so_last <= (cnt+1 == DP-1).
- Beat transfer, last (so_last=1):
  - If a word is accepted on the same edge, load it as above. No idle cycle; throughput is DP cycles per word.
  - Otherwise state <= IDLE, so_vld <= 0, so_last <= 0. so holds its last value (don't-care when so_vld=0).
- so_vld=1 & so_rdy=0: so, so_last, cnt and sr hold stable. Hold persists indefinitely, with no timeout.
- pi_vld while in SHIFT and not on the last-beat handshake: ignored (pi_rdy=0). Upstream must hold pi stable until accepted.
- cnt width is max(1, $clog2(DP)). cnt never exceeds DP-1; no wrap beyond DP-1.
- DP==1: every beat has so_last=1, and each word is one beat.
- Reset mid-word:
  - The partially sent word is discarded and all outputs go to reset values.
  - After release, the next word starts at beat 0.
- so and so_last are not combinationally dependent on pi or so_rdy.

Optional Feature:
- Macro: LIMBER_GNRL_PISO_MSB_FIRST_EN
- Defined: beat order reversed. Beat 0 = pi[(DP-1)*DW +: DW]; last beat = pi[0 +: DW].
- Undefined (default): LSB-first order as in Behaviour.
- Handshake, latency and so_last timing are identical in both builds.

Test Plan:
- Basic LSB-first (DW=4, DP=4): pi=16'hA5C3 accepted with so_rdy=1 -> so = 3,C,5,A on 4 consecutive cycles starting the cycle after acceptance; so_last=1 only with A; then so_vld=0 and pi_rdy=1.
- Backpressure: same word, so_rdy=0 for 2 cycles while beat C is shown -> so=C and so_last=0 held for 3 cycles total; sequence completes 3,C,5,A with no beat lost or duplicated.
- Back-to-back: pi_vld held with words 16'h1234 then 16'hBEEF, so_rdy=1 -> 8 consecutive valid beats 4,3,2,1,F,E,E,B; pi_rdy=1 only on reset-idle and on the beat-1 cycle; so_last on beats 1 and B.
- Reset mid-word: assert rst_asyn_n=0 after beat 5 of 16'hA5C3 -> so_vld, so, so_last go 0 without waiting for a clock edge. Then accept 16'h00F1 after release -> beats 1,F,0,0.
- DP=1 (DW=8): pi=8'h5A then 8'h3C back-to-back -> so=5A then 3C on consecutive cycles, so_last=1 on both.
- Macro defined (DW=4, DP=4): pi=16'hA5C3 -> so = A,5,C,3; so_last with 3.
